// File: rtl/io_pkg.sv
// Shared types and the address decoder for the MC14500B bit-addressed I/O block.
package io_pkg;

  localparam int unsigned IO_MIN_SYNC = 2;
  localparam int unsigned IO_IDX_W    = 16;

  typedef enum logic [1:0] {REG_OUT, REG_IN, REG_FLAG, REG_NONE} io_region_t;

  typedef struct packed {
    io_region_t            region;
    logic [IO_IDX_W-1:0]   index;
  } io_decode_t;

  // Map a bit address onto outputs, debounced inputs, edge flags or nothing.
  function automatic io_decode_t io_decode(input logic [31:0] address,
                                           input int unsigned o,
                                           input int unsigned i);
    io_decode_t d;
    d.region = REG_NONE;
    d.index  = '0;
    if (address < o) begin
      d.region = REG_OUT;
      d.index  = IO_IDX_W'(address);
    end else if (address < o + i) begin
      d.region = REG_IN;
      d.index  = IO_IDX_W'(address - o);
    end else if (address < o + 2 * i) begin
      d.region = REG_FLAG;
      d.index  = IO_IDX_W'(address - o - i);
    end
    return d;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: synchroniser chain, debounce counter, stable level and rise strobe.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise
);

  if (SYNC_STAGES < IO_MIN_SYNC) begin : g_bad_sync
    $error("io_debounce: SYNC_STAGES must be at least %0d", IO_MIN_SYNC);
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign rise = synced & ~stable_q;

    always_ff @(posedge clk) begin
      if (rst) stable_q <= 1'b0;
      else     stable_q <= synced;
    end
  end else begin : g_count
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // rise is asserted in the cycle before the edge that lifts stable, so a flag can latch on that edge
    always_comb begin
      accept = (synced != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
      rise   = accept & synced;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q    <= '0;
        stable_q <= synced;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_controller.sv
// Clocked bit-addressed I/O block: output latches with readback, debounced inputs,
// and sticky rising-edge flags cleared by any write to their address.
module io_controller
  import io_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned INPUT_SIZE      = 8,
  parameter int unsigned OUTPUT_SIZE     = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  logic                   data_in,
  output logic                   data_out,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [INPUT_SIZE-1:0]  input_pins,
  output logic [OUTPUT_SIZE-1:0] output_pins
);

  if (OUTPUT_SIZE + 2 * INPUT_SIZE > 2 ** ADDR_WIDTH) begin : g_bad_map
    $error("io_controller: address map does not fit in ADDR_WIDTH bits");
  end

  logic [OUTPUT_SIZE-1:0] out_q;
  logic [OUTPUT_SIZE-1:0] out_wr;
  logic [INPUT_SIZE-1:0]  flag_q;
  logic [INPUT_SIZE-1:0]  flag_clr;
  logic [INPUT_SIZE-1:0]  stable;
  logic [INPUT_SIZE-1:0]  rise;
  io_decode_t             dec;

  for (genvar n = 0; n < INPUT_SIZE; n++) begin : g_in
    io_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .pin    (input_pins[n]),
      .stable (stable[n]),
      .rise   (rise[n])
    );
  end

  // Decode, per-bit write enables and the read mux.
  always_comb begin
    dec      = io_decode(32'(address), OUTPUT_SIZE, INPUT_SIZE);
    out_wr   = '0;
    flag_clr = '0;
    data_out = 1'b0;
    for (int unsigned n = 0; n < OUTPUT_SIZE; n++) begin
      if (dec.region == REG_OUT && dec.index == IO_IDX_W'(n)) begin
        out_wr[n] = write;
        data_out  = out_q[n];
      end
    end
    for (int unsigned n = 0; n < INPUT_SIZE; n++) begin
      if (dec.index == IO_IDX_W'(n)) begin
        if (dec.region == REG_IN) begin
          data_out = stable[n];
        end else if (dec.region == REG_FLAG) begin
          flag_clr[n] = write;
          data_out    = flag_q[n];
        end
      end
    end
  end

  // A rise on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      flag_q <= '0;
    end else begin
      for (int unsigned n = 0; n < OUTPUT_SIZE; n++) begin
        if (out_wr[n]) out_q[n] <= data_in;
      end
      for (int unsigned n = 0; n < INPUT_SIZE; n++) begin
        if (rise[n])          flag_q[n] <= 1'b1;
        else if (flag_clr[n]) flag_q[n] <= 1'b0;
      end
    end
  end

  assign output_pins = out_q;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: vector table with a scoreboard queue plus
// hand-written debounce, flag, collision and reset sequences.
module tb_io_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic       data_in;
  logic       data_out;
  logic [5:0] address;
  logic [7:0] input_pins;
  logic [7:0] output_pins;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr;
    logic       din;
    logic [5:0] addr;
    logic       exp_dout;
    logic [7:0] exp_pins;
  } vec_t;

  typedef struct {
    string      name;
    logic       exp_dout;
    logic [7:0] exp_pins;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  io_controller #(
    .ADDR_WIDTH      (6),
    .INPUT_SIZE      (8),
    .OUTPUT_SIZE     (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .data_in     (data_in),
    .data_out    (data_out),
    .address     (address),
    .input_pins  (input_pins),
    .output_pins (output_pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic din, input logic [5:0] addr,
                              input logic exp_dout, input logic [7:0] exp_pins);
    vec_t v;
    v.wr = wr; v.din = din; v.addr = addr; v.exp_dout = exp_dout; v.exp_pins = exp_pins;
    return v;
  endfunction

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    check({e.name, "_dout"}, 32'(data_out), 32'(e.exp_dout));
    check({e.name, "_pins"}, 32'(output_pins), 32'(e.exp_pins));
  endtask

  // Wait n rising edges, sampling at the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 1'b1, 6'd3,  1'b1, 8'h08);
    vecs[1]  = mk(1'b0, 1'b0, 6'd3,  1'b1, 8'h08);
    vecs[2]  = mk(1'b1, 1'b0, 6'd3,  1'b0, 8'h00);
    vecs[3]  = mk(1'b1, 1'b1, 6'd7,  1'b1, 8'h80);
    vecs[4]  = mk(1'b0, 1'b0, 6'd7,  1'b1, 8'h80);
    vecs[5]  = mk(1'b0, 1'b0, 6'd0,  1'b0, 8'h80);
    vecs[6]  = mk(1'b1, 1'b1, 6'd40, 1'b0, 8'h80);
    vecs[7]  = mk(1'b1, 1'b1, 6'd10, 1'b0, 8'h80);
    vecs[8]  = mk(1'b1, 1'b1, 6'd16, 1'b0, 8'h80);
    vecs[9]  = mk(1'b0, 1'b0, 6'd63, 1'b0, 8'h80);
    vecs[10] = mk(1'b1, 1'b1, 6'd0,  1'b1, 8'h81);
    vecs[11] = mk(1'b1, 1'b0, 6'd0,  1'b0, 8'h80);

    // Reset with write held high must leave everything at zero.
    rst = 1'b1; write = 1'b1; data_in = 1'b1; address = 6'd3; input_pins = '0;
    edges(2);
    rst = 1'b0; write = 1'b0; data_in = 1'b0;
    check("reset_pins", 32'(output_pins), 32'h0);
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      #1;
      check($sformatf("reset_read_%0d", a), 32'(data_out), 32'h0);
    end

    // Vector table through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      @(negedge clk);
      if (sb.size() != 0) pop_compare();
      write = vecs[i].wr; data_in = vecs[i].din; address = vecs[i].addr;
      e.name = $sformatf("vec%0d", i);
      e.exp_dout = vecs[i].exp_dout;
      e.exp_pins = vecs[i].exp_pins;
      sb.push_back(e);
    end
    @(negedge clk);
    write = 1'b0;
    pop_compare();

    // Write and read of the same latch: old value this cycle, new value after the edge.
    address = 6'd5; data_in = 1'b1; write = 1'b1;
    #1;
    check("rw_same_old", 32'(data_out), 32'h0);
    @(negedge clk);
    write = 1'b0;
    #1;
    check("rw_same_new", 32'(data_out), 32'h1);
    check("rw_same_pins", 32'(output_pins), 32'hA0);

    // Debounce: a 15-cycle pulse never changes input 2.
    address = 6'd10;
    input_pins[2] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      edges(1);
      check($sformatf("glitch_%0d", k), 32'(data_out), 32'h0);
    end
    input_pins[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      check($sformatf("glitch_tail_%0d", k), 32'(data_out), 32'h0);
    end

    // Debounce: held level is accepted on edge 2+16.
    input_pins[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      edges(1);
      check($sformatf("hold_%0d", k), 32'(data_out), (k >= 18) ? 32'h1 : 32'h0);
    end
    address = 6'd18;
    #1;
    check("flag2_set", 32'(data_out), 32'h1);

    // Edge flag 0: set on the rise, cleared by a write, untouched by a fall.
    address = 6'd16;
    input_pins[0] = 1'b1;
    edges(17);
    check("flag0_before", 32'(data_out), 32'h0);
    edges(1);
    check("flag0_rise", 32'(data_out), 32'h1);
    edges(3);
    check("flag0_sticky", 32'(data_out), 32'h1);
    write = 1'b1; data_in = 1'b0;
    edges(1);
    write = 1'b0;
    #1;
    check("flag0_cleared", 32'(data_out), 32'h0);
    input_pins[0] = 1'b0;
    edges(20);
    check("flag0_after_fall", 32'(data_out), 32'h0);
    address = 6'd8;
    #1;
    check("in0_fell", 32'(data_out), 32'h0);

    // Collision: clear of flag 1 on the edge where input 1 rises; set wins.
    address = 6'd9;
    input_pins[1] = 1'b1;
    edges(17);
    check("in1_before", 32'(data_out), 32'h0);
    address = 6'd17; write = 1'b1; data_in = 1'b0;
    edges(1);
    write = 1'b0;
    #1;
    check("collision_flag1", 32'(data_out), 32'h1);
    address = 6'd9;
    #1;
    check("in1_risen", 32'(data_out), 32'h1);
    address = 6'd17; write = 1'b1;
    edges(1);
    write = 1'b0;
    #1;
    check("flag1_clear_later", 32'(data_out), 32'h0);

    // Out-of-range write changes nothing.
    address = 6'd40; write = 1'b1; data_in = 1'b1;
    edges(1);
    write = 1'b0;
    #1;
    check("oor_read", 32'(data_out), 32'h0);
    check("oor_pins", 32'(output_pins), 32'hA0);

    // Reset mid-debounce restarts the count from zero.
    address = 6'd13;
    input_pins[5] = 1'b1;
    edges(10);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    check("rst_mid_pins", 32'(output_pins), 32'h0);
    for (int k = 1; k <= 19; k++) begin
      edges(1);
      check($sformatf("rst_mid_%0d", k), 32'(data_out), (k >= 18) ? 32'h1 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
